// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if
// Bundle between the MEM stage / decode (master side) and the write-back stage
// (slave side).
//   MEM -> WB   : in_valid, in_data, in_dst, in_regwrite, in_halt, stall, flush
//   decode -> WB: rd_addr1, rd_addr2
//   WB -> regs  : wb_data, wb_we (one-hot per register), wb_dst, wb_valid
//   WB -> core  : halted, retire_cnt
//   WB -> decode: byp_hit1, byp_hit2, byp_data
// ---------------------------------------------------------------------------
interface wb_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    localparam int NREG = 2 ** ADDR_W;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_dst;
    logic              in_regwrite;
    logic              in_halt;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;

    logic [DATA_W-1:0] wb_data;
    logic [NREG-1:0]   wb_we;
    logic [ADDR_W-1:0] wb_dst;
    logic              wb_valid;
    logic              halted;
    logic [15:0]       retire_cnt;
    logic              byp_hit1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data;

    modport master (
        output in_valid, in_data, in_dst, in_regwrite, in_halt, stall, flush,
               rd_addr1, rd_addr2,
        input  wb_data, wb_we, wb_dst, wb_valid, halted, retire_cnt,
               byp_hit1, byp_hit2, byp_data
    );

    modport slave (
        input  in_valid, in_data, in_dst, in_regwrite, in_halt, stall, flush,
               rd_addr1, rd_addr2,
        output wb_data, wb_we, wb_dst, wb_valid, halted, retire_cnt,
               byp_hit1, byp_hit2, byp_data
    );
endinterface

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// MEM/WB pipeline register plus register-file write driver of the 16-bit core.
// Latches the retiring instruction, drives write data and one-hot write enables
// into the register array, counts retired instructions and keeps a sticky halt
// flag.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - wb_stage_if.slave (MEM inputs, stall/flush, read addresses,
//          write-back outputs, halted, retire_cnt, bypass outputs)
// Build option:
//   WB_BYPASS_EN - when defined, byp_hit1/byp_hit2 flag a same-cycle
//                  write-then-read on each read port; otherwise they are 0.
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              regwrite_q, regwrite_d;
    logic              halt_q, halt_d;
    logic              halted_q, halted_d;
    logic [15:0]       retire_cnt_q, retire_cnt_d;

    logic              retire;
    logic              halt_set;
    logic              wr_active;
    logic [NREG-1:0]   we;

    always_comb begin
        // The held instruction leaves the stage whenever it is not stalled;
        // a flush replaces it with a bubble but does not cancel its retirement.
        retire       = valid_q & ~bus.stall;
        halt_set     = retire & halt_q;
        halted_d     = halted_q | halt_set;
        retire_cnt_d = retire ? retire_cnt_q + 16'd1 : retire_cnt_q;

        valid_d    = valid_q;
        data_d     = data_q;
        dst_d      = dst_q;
        regwrite_d = regwrite_q;
        halt_d     = halt_q;

        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            // Gating with halted_d (not halted_q) also drops the instruction
            // right behind the HLT, so nothing after the HLT ever retires.
            valid_d    = bus.in_valid & ~halted_d;
            data_d     = bus.in_data;
            dst_d      = bus.in_dst;
            regwrite_d = bus.in_regwrite;
            halt_d     = bus.in_halt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            data_q       <= '0;
            dst_q        <= '0;
            regwrite_q   <= 1'b0;
            halt_q       <= 1'b0;
            halted_q     <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            dst_q        <= dst_d;
            regwrite_q   <= regwrite_d;
            halt_q       <= halt_d;
            halted_q     <= halted_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Register 0 is hard-wired; it never receives a write enable.
    assign wr_active = valid_q & regwrite_q & (dst_q != '0);

    always_comb begin
        we = '0;
        if (wr_active) begin
            we[dst_q] = 1'b1;
        end
    end

    assign bus.wb_data    = data_q;
    assign bus.wb_we      = we;
    assign bus.wb_dst     = dst_q;
    assign bus.wb_valid   = valid_q;
    assign bus.halted     = halted_q;
    assign bus.retire_cnt = retire_cnt_q;
    assign bus.byp_data   = data_q;

`ifdef WB_BYPASS_EN
    assign bus.byp_hit1 = wr_active & (dst_q == bus.rd_addr1);
    assign bus.byp_hit2 = wr_active & (dst_q == bus.rd_addr2);
`else
    // Without bypass, decode interlocks on the dependency instead.
    logic unused_rd_addr;
    assign unused_rd_addr = ^{bus.rd_addr1, bus.rd_addr2};
    assign bus.byp_hit1   = 1'b0;
    assign bus.byp_hit2   = 1'b0;
`endif

endmodule
